// File: rtl/fpu_issue.sv
// fpu_issue: hands one operation to a selectable FPU unit and waits for its result.
// Define FPU_ISSUE_TIMEOUT_EN to add a WAIT timeout that returns quiet NaN and pulses err.
module fpu_issue #(
    parameter int TIMEOUT = 64,
    parameter int NUNIT   = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req,
    input  logic [$clog2(NUNIT)-1:0] op,
    input  logic [31:0]              a,
    input  logic [31:0]              b,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              result,
`ifdef FPU_ISSUE_TIMEOUT_EN
    output logic                     err,
`endif
    output logic [31:0]              fu_x1,
    output logic [31:0]              fu_x2,
    output logic [$clog2(NUNIT)-1:0] fu_sel,
    output logic                     fu_ready,
    input  logic                     fu_valid,
    input  logic [31:0]              fu_y
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       w_capture;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_fu_ready;
    logic [31:0]                r_result;
    logic [31:0]                r_fu_x1;
    logic [31:0]                r_fu_x2;
    logic [$clog2(NUNIT)-1:0]   r_fu_sel;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic [7:0]  TMO  = 8'(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_abort;
    logic       w_cnt_last;

    // True during the last WAIT cycle allowed before the abort.
    assign w_cnt_last = (r_cnt == TMO - 8'd1);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        w_abort   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) w_next = S_ISSUE;
            end
            S_ISSUE, S_WAIT: begin
                if (fu_valid) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end else if (r_state == S_ISSUE) begin
                    w_next = S_WAIT;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (w_cnt_last) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
`endif
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are flops loaded from the next state, so they align with r_state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fu_ready <= 1'b0;
            r_result   <= 32'h0;
            r_fu_x1    <= 32'h0;
            r_fu_x2    <= 32'h0;
            r_fu_sel   <= '0;
        end else begin
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            r_fu_ready <= (w_next == S_ISSUE);
            if (r_state == S_IDLE && req) begin
                r_fu_x1  <= a;
                r_fu_x2  <= b;
                r_fu_sel <= op;
            end
            if (w_capture) r_result <= fu_y;
`ifdef FPU_ISSUE_TIMEOUT_EN
            if (w_abort) r_result <= QNAN;
`endif
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (w_next == S_ISSUE)
                r_cnt <= 8'd0;
            else if (r_state == S_WAIT && r_cnt != TMO)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign err = r_err;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign fu_ready = r_fu_ready;
    assign result   = r_result;
    assign fu_x1    = r_fu_x1;
    assign fu_x2    = r_fu_x2;
    assign fu_sel   = r_fu_sel;

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed plus randomized operations against a transaction-level timing model.
// Works with or without FPU_ISSUE_TIMEOUT_EN; timeout expectations follow the macro.
module tb_fpu_issue;

    localparam int          TMO  = 8;
    localparam logic [31:0] QNAN = 32'h7FC00000;
`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam bit HAS_TMO = 1'b1;
`else
    localparam bit HAS_TMO = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        req      = 1'b0;
    logic [1:0]  op       = 2'd0;
    logic [31:0] a        = 32'h0;
    logic [31:0] b        = 32'h0;
    logic        fu_valid = 1'b0;
    logic [31:0] fu_y     = 32'h0;
    logic        busy;
    logic        done;
    logic        fu_ready;
    logic [31:0] result;
    logic [31:0] fu_x1;
    logic [31:0] fu_x2;
    logic [1:0]  fu_sel;
`ifdef FPU_ISSUE_TIMEOUT_EN
    logic        err;
`endif

    int tests          = 0;
    int fails          = 0;
    int cyc            = 0;
    int last_ready_cyc = -100;
    int last_gap       = 0;

    fpu_issue #(.TIMEOUT(TMO), .NUNIT(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
`ifdef FPU_ISSUE_TIMEOUT_EN
        .err      (err),
`endif
        .fu_x1    (fu_x1),
        .fu_x2    (fu_x2),
        .fu_sel   (fu_sel),
        .fu_ready (fu_ready),
        .fu_valid (fu_valid),
        .fu_y     (fu_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_at;
        bit          err;
        logic [31:0] res;
    } exp_t;

    // Cycle 0 holds req; the unit raises valid lat cycles after the ready cycle (cycle 1).
    function automatic exp_t predict(input int lat, input logic [31:0] y);
        exp_t e;
        if (HAS_TMO && lat > TMO) begin
            e.done_at = TMO + 2;
            e.err     = 1'b1;
            e.res     = QNAN;
        end else begin
            e.done_at = lat + 2;
            e.err     = 1'b0;
            e.res     = y;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},     32'(busy),     32'h0);
        check({tag, ".done"},     32'(done),     32'h0);
        check({tag, ".fu_ready"}, 32'(fu_ready), 32'h0);
        check({tag, ".result"},   result,        32'h0);
        check({tag, ".fu_x1"},    fu_x1,         32'h0);
        check({tag, ".fu_x2"},    fu_x2,         32'h0);
        check({tag, ".fu_sel"},   32'(fu_sel),   32'h0);
`ifdef FPU_ISSUE_TIMEOUT_EN
        check({tag, ".err"},      32'(err),      32'h0);
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] y_i, input int lat,
                          input bit poke);
        exp_t        e;
        int          n_ready;
        int          n_done;
        int          n_busy;
        int          n_err;
        int          at_ready;
        int          at_done;
        int          at_err;
        logic [31:0] res_done;
        e        = predict(lat, y_i);
        n_ready  = 0;
        n_done   = 0;
        n_busy   = 0;
        n_err    = 0;
        at_ready = -1;
        at_done  = -1;
        at_err   = -1;
        res_done = 32'h0;
        check({tag, ".idle"}, 32'(busy), 32'h0);
        req      = 1'b1;
        op       = op_i;
        a        = a_i;
        b        = b_i;
        fu_valid = 1'($urandom);
        fu_y     = $urandom;
        for (int c = 1; c <= e.done_at + 1; c++) begin
            @(negedge clk);
            if (fu_ready) begin
                n_ready++;
                at_ready       = c;
                last_gap       = cyc - last_ready_cyc;
                last_ready_cyc = cyc;
            end
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                at_done  = c;
                res_done = result;
            end
`ifdef FPU_ISSUE_TIMEOUT_EN
            if (err) begin
                n_err++;
                at_err = c;
            end
`endif
            if (c == 1) begin
                check({tag, ".fu_x1"},  fu_x1,       a_i);
                check({tag, ".fu_x2"},  fu_x2,       b_i);
                check({tag, ".fu_sel"}, 32'(fu_sel), 32'(op_i));
            end
            if (c == e.done_at)
                check({tag, ".fu_x2_hold"}, fu_x2, b_i);
            req      = poke && (c == 2);
            b        = (poke && c == 2) ? 32'h12345678 : b_i;
            fu_valid = (c == lat + 1) || (c == e.done_at);
            fu_y     = (c == lat + 1) ? y_i : $urandom;
        end
        req      = 1'b0;
        fu_valid = 1'b0;
        check({tag, ".ready_cnt"},   32'(n_ready),  32'd1);
        check({tag, ".ready_at"},    32'(at_ready), 32'd1);
        check({tag, ".done_cnt"},    32'(n_done),   32'd1);
        check({tag, ".done_at"},     32'(at_done),  32'(e.done_at));
        check({tag, ".busy_cycles"}, 32'(n_busy),   32'(e.done_at));
        check({tag, ".result"},      res_done,      e.res);
        check({tag, ".result_hold"}, result,        e.res);
`ifdef FPU_ISSUE_TIMEOUT_EN
        check({tag, ".err_cnt"},     32'(n_err),    32'(e.err));
        if (e.err) check({tag, ".err_at"}, 32'(at_err), 32'(at_done));
`else
        n_err  = n_err + at_err;
`endif
    endtask

    initial begin
        int n_done;
        int n_busy;
        int n_ready;

        // Reset state, then first req on the first edge after release
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        run_op("single", 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 1'b0);
        run_op("zero_lat", 2'($urandom), $urandom, $urandom, 32'hC0000000, 0, 1'b0);
        run_op("busy_req", 2'd2, $urandom, $urandom, $urandom, 3, 1'b1);

        // Timeout path (or a long wait when the feature is absent), and its boundary
        run_op("timeout", 2'd1, $urandom, $urandom, $urandom, HAS_TMO ? 1000 : 3 * TMO, 1'b0);
        run_op("tmo_edge", 2'd2, $urandom, $urandom, $urandom, TMO, 1'b0);
        run_op("after_tmo", 2'd0, $urandom, $urandom, $urandom, 1, 1'b0);

        // Back-to-back with op=1 then op=3
        run_op("b2b_op1", 2'd1, $urandom, $urandom, $urandom, $urandom_range(1, 5), 1'b0);
        run_op("b2b_op3", 2'd3, $urandom, $urandom, $urandom, $urandom_range(1, 5), 1'b0);
        check("b2b.ready_gap_ge4", 32'(last_gap >= 4), 32'd1);

        // Reset in WAIT abandons the operation; a late valid after release is ignored
        req = 1'b1;
        op  = 2'd3;
        a   = $urandom | 32'h1;
        b   = $urandom | 32'h1;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rstn     = 1'b1;
        fu_valid = 1'b1;
        fu_y     = $urandom | 32'h1;
        n_done   = 0;
        n_busy   = 0;
        n_ready  = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done)     n_done++;
            if (busy)     n_busy++;
            if (fu_ready) n_ready++;
        end
        fu_valid = 1'b0;
        check("mid_reset.no_done",  32'(n_done),  32'd0);
        check("mid_reset.no_busy",  32'(n_busy),  32'd0);
        check("mid_reset.no_ready", 32'(n_ready), 32'd0);
        check_reset_outputs("post_reset");

        // Randomized operations against the model
        for (int i = 0; i < 8; i++)
            run_op("rand", 2'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, 12), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT before abort; legal range 2..255.
REQ-002 Parameter NUNIT, default 4: number of selectable FPU units; fu_sel width is 2.
REQ-003 Port clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-004 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port req, input, 1 bit: core request strobe, sampled only in IDLE.
REQ-006 Port op, input, 2 bits: unit select from the core, captured with req.
REQ-007 Port a and port b, input, 32 bits each: IEEE-754 single-precision operands, captured with req.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.
REQ-009 Port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-010 Port result, output, 32 bits: captured unit output; holds its value until the next capture.
REQ-011 Port err, output, 1 bit: one-cycle pulse on timeout abort; present only with the macro defined.
REQ-012 Ports fu_x1 and fu_x2, output, 32 bits each: operands to the unit; registered; stable from ISSUE until the state returns to IDLE.
REQ-013 Port fu_sel, output, 2 bits: registered unit select.
REQ-014 Port fu_ready, output, 1 bit: start strobe to the unit; high for exactly one cycle per operation.
REQ-015 Port fu_valid, input, 1 bit: completion strobe from the selected unit.
REQ-016 Port fu_y, input, 32 bits: unit result, qualified by fu_valid.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; all outputs SHALL be registered.
- IDLE to ISSUE: on a clock edge with req=1. The block captures a, b and op into fu_x1, fu_x2 and fu_sel.
- ISSUE: fu_ready=1 for this cycle only.
- ISSUE or WAIT to DONE: on a clock edge with fu_valid=1. The block captures fu_y into result.
- ISSUE to WAIT: on a clock edge with fu_valid=0.
- DONE to IDLE: unconditional. done=1 during the DONE cycle.
REQ-018 Minimum latency, req edge to done high: 2 cycles, for a unit that asserts valid in the same cycle as ready. A unit with latency L gives L+2 cycles.
REQ-019 The block SHALL ignore req while busy=1; no queuing.
REQ-020 The block SHALL ignore fu_valid in IDLE and DONE; result SHALL NOT change in those states.
REQ-021 If req and a late fu_valid arrive in the same IDLE cycle, the block SHALL start the new request and discard the valid.
REQ-022 A WAIT cycle counter SHALL clear on entry to ISSUE, saturate at TIMEOUT and never wrap.
REQ-023 fu_ready SHALL NOT be asserted again before the block returns to IDLE.

Reset
REQ-024 While rstn=0, the block SHALL apply the following asynchronously:
- state = IDLE.
- busy, done, err and fu_ready = 0.
- result, fu_x1 and fu_x2 = 32'h0.
- fu_sel = 0.
- counter = 0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation. No done and no err pulse SHALL follow the release of reset.
REQ-026 The first req is accepted on the first clock edge after rstn deasserts.

Configuration
REQ-027 Macro FPU_ISSUE_TIMEOUT_EN SHALL control the timeout feature.
- Defined: when the counter reaches TIMEOUT in WAIT without fu_valid, the block enters DONE with result=32'h7FC00000 (quiet NaN). The err pulse and the done pulse occur in the same DONE cycle.
- Defined: fu_valid arriving in the timeout cycle wins, giving normal capture with no err.
- Not defined: the err port and the counter are absent, and WAIT persists until fu_valid.

Verification
REQ-028 Single operation:
- Stimulus: reset, then req, op=0, a=32'h3F800000, b=32'h40000000; unit model returns fu_y=32'h40400000 three cycles after fu_ready.
- Response: fu_ready high for exactly 1 cycle; done at 5 cycles after req; result=32'h40400000; busy high for 5 cycles.
REQ-029 Zero-latency unit:
- Stimulus: fu_valid driven high in the ISSUE cycle with fu_y=32'hC0000000.
- Response: done 2 cycles after req; result=32'hC0000000.
REQ-030 Request while busy:
- Stimulus: a second req with b=32'h12345678 while in WAIT.
- Response: fu_x2 unchanged; only one fu_ready pulse; exactly one done.
REQ-031 Reset mid-operation:
- Stimulus: rstn pulsed low in WAIT, then fu_valid=1 after release.
- Response: every output at its reset value; no done pulse; result=32'h0.
REQ-032 Timeout, macro defined, TIMEOUT=8:
- Stimulus: fu_valid never asserted.
- Response: done=1 and err=1 in the same cycle, 8 WAIT cycles after ISSUE; result=32'h7FC00000; next req accepted.
REQ-033 Back-to-back operations with op=1, then op=3:
- Response: fu_sel follows op; the two fu_ready pulses are at least 4 cycles apart; two done pulses with the correct results.
